// File: rtl/oht_multi_channel.sv
// N-channel online health test with closed-loop trim calibration.
// Each channel runs a repetition-count test and a windowed adaptive-proportion test.
module oht_multi_channel #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned TRIM_W     = 6,
    parameter int unsigned WIN_LOG2   = 10,
    parameter int unsigned RCT_CUTOFF = 32,
    parameter int unsigned APT_LO     = 461,
    parameter int unsigned APT_HI     = 562,
    parameter int unsigned MAX_RETRY  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CH-1:0]           adc_in,
    input  logic                      full,
    input  logic                      debug_mode,
    input  logic [2*TRIM_W-1:0]       spi_trim,
    input  logic [$clog2(N_CH)-1:0]   spi_ch_sel,
    output logic [N_CH-1:0]           valid,
    output logic [N_CH-1:0]           perm_fail,
    output logic [N_CH*TRIM_W-1:0]    trim_n,
    output logic [N_CH*TRIM_W-1:0]    trim_p,
    output logic [2*N_CH-1:0]         ch_state
);

    localparam int unsigned W        = 1 << WIN_LOG2;
    localparam int unsigned CNT_W    = WIN_LOG2 + 1;
    localparam int unsigned RUN_W    = $clog2(RCT_CUTOFF + 1);
    localparam int unsigned RETRY_W  = $clog2(MAX_RETRY + 1);
    localparam int unsigned SEL_W    = $clog2(N_CH);
    localparam int unsigned TW1      = TRIM_W + 1;
    localparam int unsigned TRIM_RST = 1 << (TRIM_W - 1);

    typedef enum logic [1:0] {
        ST_CAL  = 2'd0,
        ST_RUN  = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    // Input sample stage; a held sample is only consumed on a non-full edge.
    logic [N_CH-1:0] r_smp;
    logic            r_smp_vld;
    logic            w_adv;

    assign w_adv = !full && r_smp_vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_smp     <= '0;
            r_smp_vld <= 1'b0;
        end else if (!full) begin
            r_smp     <= adc_in;
            r_smp_vld <= 1'b1;
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        state_t             r_state, w_state_nxt;
        logic               r_prev, w_prev_nxt;
        logic               r_valid, w_valid_nxt;
        logic               r_perm_fail, w_perm_fail_nxt;
        logic [RUN_W-1:0]   r_run_len, w_run_inc, w_run_len_nxt;
        logic [CNT_W-1:0]   r_win_cnt, w_win_cnt_nxt;
        logic [CNT_W-1:0]   r_ones, w_ones_inc, w_ones_nxt;
        logic [RETRY_W-1:0] r_retry, w_retry_nxt;
        logic [TRIM_W-1:0]  r_trim_n, r_trim_p, w_trim_n_nxt, w_trim_p_nxt;
        logic [TW1-1:0]     w_p_up, w_p_dn, w_n_up, w_n_dn;
        logic [1:0]         w_step;
        logic               w_smp, w_rct_hit, w_win_end, w_in_range;
        logic               w_fail_evt, w_pass_evt, w_high, w_adj, w_spi_hit;

        always_comb begin
            w_smp      = r_smp[gi];
            w_run_inc  = (r_run_len != '0 && w_smp == r_prev) ? r_run_len + RUN_W'(1) : RUN_W'(1);
            w_rct_hit  = (w_run_inc == RUN_W'(RCT_CUTOFF));
            w_ones_inc = r_ones + CNT_W'(w_smp);
            w_win_end  = (r_win_cnt == CNT_W'(W - 1));
            w_in_range = (w_ones_inc >= CNT_W'(APT_LO)) && (w_ones_inc <= CNT_W'(APT_HI));
            w_fail_evt = w_rct_hit || (w_win_end && !w_in_range);
            w_pass_evt = w_win_end && !w_rct_hit && w_in_range;
            w_spi_hit  = debug_mode && (spi_ch_sel == SEL_W'(gi));

            // A stuck run counts as the extreme case of its own polarity.
            w_high = w_rct_hit ? w_smp : (w_ones_inc > CNT_W'(W / 2));
            if (w_rct_hit)
                w_step = 2'd3;
            else if (w_ones_inc < CNT_W'(W / 8) || w_ones_inc > CNT_W'(7 * W / 8))
                w_step = 2'd3;
            else if (w_ones_inc < CNT_W'(W / 4) || w_ones_inc > CNT_W'(3 * W / 4))
                w_step = 2'd2;
            else
                w_step = 2'd1;

            w_p_up = {1'b0, r_trim_p} + TW1'(w_step);
            w_p_dn = {1'b0, r_trim_p} - TW1'(w_step);
            w_n_up = {1'b0, r_trim_n} + TW1'(w_step);
            w_n_dn = {1'b0, r_trim_n} - TW1'(w_step);

            w_state_nxt   = r_state;
            w_prev_nxt    = r_prev;
            w_run_len_nxt = r_run_len;
            w_win_cnt_nxt = r_win_cnt;
            w_ones_nxt    = r_ones;
            w_retry_nxt   = r_retry;
            w_trim_n_nxt  = r_trim_n;
            w_trim_p_nxt  = r_trim_p;
            w_adj         = 1'b0;

            if (w_adv) begin
                w_prev_nxt    = w_smp;
                w_run_len_nxt = w_rct_hit ? RUN_W'(1) : w_run_inc;
                if (w_rct_hit || w_win_end) begin
                    w_win_cnt_nxt = '0;
                    w_ones_nxt    = '0;
                end else begin
                    w_win_cnt_nxt = r_win_cnt + CNT_W'(1);
                    w_ones_nxt    = w_ones_inc;
                end
                case (r_state)
                    ST_CAL: begin
                        if (w_pass_evt) begin
                            w_state_nxt = ST_RUN;
                            w_retry_nxt = '0;
                        end else if (w_fail_evt) begin
                            w_adj       = 1'b1;
                            w_retry_nxt = r_retry + RETRY_W'(1);
                            if (w_retry_nxt >= RETRY_W'(MAX_RETRY))
                                w_state_nxt = ST_FAIL;
                        end
                    end
                    ST_RUN: begin
                        if (w_fail_evt) begin
                            w_adj       = 1'b1;
                            w_retry_nxt = RETRY_W'(1);
                            w_state_nxt = ST_CAL;
                        end
                    end
                    default: ;
                endcase
            end

            // Saturating trim steer; n-array only moves once p-array is pinned.
            if (w_adj && !debug_mode) begin
                if (w_high) begin
                    if (r_trim_p == '0)
                        w_trim_n_nxt = w_n_up[TRIM_W] ? '1 : w_n_up[TRIM_W-1:0];
                    else
                        w_trim_p_nxt = w_p_dn[TRIM_W] ? '0 : w_p_dn[TRIM_W-1:0];
                end else begin
                    if (r_trim_p == '1)
                        w_trim_n_nxt = w_n_dn[TRIM_W] ? '0 : w_n_dn[TRIM_W-1:0];
                    else
                        w_trim_p_nxt = w_p_up[TRIM_W] ? '1 : w_p_up[TRIM_W-1:0];
                end
            end

            if (w_spi_hit && !full && r_state != ST_FAIL) begin
                w_trim_n_nxt = spi_trim[2*TRIM_W-1:TRIM_W];
                w_trim_p_nxt = spi_trim[TRIM_W-1:0];
            end

            w_valid_nxt     = (w_state_nxt == ST_RUN);
            w_perm_fail_nxt = (w_state_nxt == ST_FAIL);
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state     <= ST_CAL;
                r_prev      <= 1'b0;
                r_run_len   <= '0;
                r_win_cnt   <= '0;
                r_ones      <= '0;
                r_retry     <= '0;
                r_trim_n    <= TRIM_W'(TRIM_RST);
                r_trim_p    <= TRIM_W'(TRIM_RST);
                r_valid     <= 1'b0;
                r_perm_fail <= 1'b0;
            end else begin
                r_state     <= w_state_nxt;
                r_prev      <= w_prev_nxt;
                r_run_len   <= w_run_len_nxt;
                r_win_cnt   <= w_win_cnt_nxt;
                r_ones      <= w_ones_nxt;
                r_retry     <= w_retry_nxt;
                r_trim_n    <= w_trim_n_nxt;
                r_trim_p    <= w_trim_p_nxt;
                r_valid     <= w_valid_nxt;
                r_perm_fail <= w_perm_fail_nxt;
            end
        end

        assign valid[gi]                     = r_valid;
        assign perm_fail[gi]                 = r_perm_fail;
        assign trim_n[gi*TRIM_W +: TRIM_W]   = r_trim_n;
        assign trim_p[gi*TRIM_W +: TRIM_W]   = r_trim_p;
        assign ch_state[2*gi +: 2]           = r_state;
    end

endmodule
